mem_arbiter: RTL and testbench

- Two-requester arbiter for the single data memory/IO port (Memory block: wen, ren, addr, wdata, rdata).
- Port 0 is the core load/store path; port 1 is a secondary master (UART bootloader/DMA) that writes program data and inspects IO registers.
- Selects one master per cycle and drives the shared memory strobes.
- Owner keeps the port while it holds req, bounded by a hold limit; otherwise round-robin.
- Routes one-cycle-latency read data back to the master that issued the read.

---
 rtl/mem_arbiter_pkg.sv | 29 ++
 rtl/mem_arbiter_if.sv | 52 +++++
 rtl/mem_arbiter_arb_rr2.sv | 46 ++++
 rtl/mem_arbiter.sv | 105 ++++++++++
 tb/tb_mem_arbiter.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared owner-state encoding and defaults for the two-port
//               data-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    // Owner states; the debug owner port exposes this encoding.
    typedef enum logic [1:0] {
        OWNER_IDLE = 2'd0,
        OWNER_P0   = 2'd1,
        OWNER_P1   = 2'd2
    } owner_e;

    localparam logic [1:0] c_own_idle = 2'd0;
    localparam logic [1:0] c_own0     = 2'd1;
    localparam logic [1:0] c_own1     = 2'd2;

    localparam int c_max_hold_def = 8;

    // Owner state that corresponds to a granted port index.
    function automatic logic [1:0] f_owner_of(input logic sel);
        return sel ? c_own1 : c_own0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Bus bundle for the two requesters and the shared memory port.
//               slave = arbiter side, master = requesters plus memory side.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              gnt0;
    logic              rvalid0;
    logic [DATA_W-1:0] rdata0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt1;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata1;

    logic              mem_wen;
    logic              mem_ren;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_rdata,
        output gnt0, rvalid0, rdata0,
        output gnt1, rvalid1, rdata1,
        output mem_wen, mem_ren, mem_addr, mem_wdata
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_rdata,
        input  gnt0, rvalid0, rdata0,
        input  gnt1, rvalid1, rdata1,
        input  mem_wen, mem_ren, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter_arb_rr2.sv
`default_nettype none
// ============================================================================
// Module      : arb_rr2
// Description : Combinational 2-way winner select with owner hold, hold-limit
//               preemption and round-robin tie-break from idle.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_rr2
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = c_max_hold_def,
    parameter int HOLD_W   = 4
) (
    input  wire logic [1:0]        req,
    input  wire logic [1:0]        owner,
    input  wire logic [HOLD_W-1:0] hold_cnt,
    input  wire logic              rr_ptr,
    output logic                   sel,
    output logic                   valid
);

    logic w_below_limit;
    assign w_below_limit = (hold_cnt < HOLD_W'(MAX_HOLD));

    // Pick the winner: lone requester wins; under contention the owner keeps
    // the port until the hold limit, and from idle the round-robin pointer decides.
    always_comb begin
        sel   = 1'b0;
        valid = |req;
        unique case (req)
            2'b01:   sel = 1'b0;
            2'b10:   sel = 1'b1;
            2'b11: begin
                if (owner == c_own0)
                    sel = w_below_limit ? 1'b0 : 1'b1;
                else if (owner == c_own1)
                    sel = w_below_limit ? 1'b1 : 1'b0;
                else
                    sel = rr_ptr;
            end
            default: sel = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-requester arbiter for the single data memory/IO port.
//               Zero-latency grant, bounded owner hold, round-robin fairness,
//               one-cycle read data routed back to the issuing requester.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = c_max_hold_def
) (
    input  wire logic       clk,
    input  wire logic       rst,      // asynchronous, active low
    mem_arbiter_if.slave    bus,
    output logic [1:0]      owner
);

    localparam int c_hold_w = $clog2(MAX_HOLD + 1);

    logic [1:0]          r_owner;
    logic [c_hold_w-1:0] r_hold_cnt;
    logic                r_rr_ptr;
    logic                r_rd_pend;
    logic                r_rd_port;

    logic                w_sel;
    logic                w_valid;
    logic                w_win;
    logic                w_we;
    logic [1:0]          w_owner_nxt;
    logic [c_hold_w-1:0] w_hold_nxt;

    arb_rr2 #(
        .MAX_HOLD (MAX_HOLD),
        .HOLD_W   (c_hold_w)
    ) u_arb (
        .req      ({bus.req1, bus.req0}),
        .owner    (r_owner),
        .hold_cnt (r_hold_cnt),
        .rr_ptr   (r_rr_ptr),
        .sel      (w_sel),
        .valid    (w_valid)
    );

    // Grants and strobes are forced low while reset is held.
    assign w_win = w_valid & rst;
    assign w_we  = w_sel ? bus.we1 : bus.we0;

    assign bus.gnt0 = w_win & ~w_sel;
    assign bus.gnt1 = w_win &  w_sel;

    assign bus.mem_wen   = w_win &  w_we;
    assign bus.mem_ren   = w_win & ~w_we;
    assign bus.mem_addr  = w_win ? (w_sel ? bus.addr1  : bus.addr0)  : '0;
    assign bus.mem_wdata = w_win ? (w_sel ? bus.wdata1 : bus.wdata0) : '0;

    // Read data is steered by the port captured at grant time, so a later
    // owner switch cannot misroute or drop an outstanding response.
    assign bus.rvalid0 = r_rd_pend & ~r_rd_port;
    assign bus.rvalid1 = r_rd_pend &  r_rd_port;
    assign bus.rdata0  = bus.rvalid0 ? bus.mem_rdata : '0;
    assign bus.rdata1  = bus.rvalid1 ? bus.mem_rdata : '0;

    assign owner = r_owner;

    // Next owner and saturating hold count for the current winner.
    always_comb begin
        w_owner_nxt = c_own_idle;
        w_hold_nxt  = '0;
        if (w_win) begin
            w_owner_nxt = f_owner_of(w_sel);
            if (w_owner_nxt != r_owner)
                w_hold_nxt = c_hold_w'(1);
            else if (r_hold_cnt == c_hold_w'(MAX_HOLD))
                w_hold_nxt = r_hold_cnt;
            else
                w_hold_nxt = r_hold_cnt + c_hold_w'(1);
        end
    end

    // Arbitration state and read-return tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner    <= c_own_idle;
            r_hold_cnt <= '0;
            r_rr_ptr   <= 1'b0;
            r_rd_pend  <= 1'b0;
            r_rd_port  <= 1'b0;
        end else begin
            r_owner    <= w_owner_nxt;
            r_hold_cnt <= w_hold_nxt;
            if (w_win)
                r_rr_ptr <= ~w_sel;
            r_rd_pend  <= w_win & ~w_we;
            if (w_win & ~w_we)
                r_rd_port <= w_sel;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter with a small
//               one-cycle-latency memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] owner;

    int n_checks = 0;
    int n_pass   = 0;

    mem_arbiter_if #(.ADDR_W(16), .DATA_W(32)) bus ();

    mem_arbiter #(
        .ADDR_W   (16),
        .DATA_W   (32),
        .MAX_HOLD (8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .owner (owner)
    );

    always #5 clk = ~clk;

    // Memory model: word i preloads to 0xA000_0000 | i; read data one cycle after ren.
    logic [31:0] mem [0:255];
    logic [31:0] mem_rdata_q = 32'h0;
    logic        mem_ready   = 1'b0;
    assign bus.mem_rdata = mem_rdata_q;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++)
                mem[i] <= 32'hA000_0000 | 32'(i);
            mem_ready <= 1'b1;
        end else begin
            if (bus.mem_wen)
                mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
            if (bus.mem_ren)
                mem_rdata_q <= mem[bus.mem_addr[9:2]];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;

        // Reset held with a pending write request.
        repeat (2) @(posedge clk);
        #1;
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 16'h0010; bus.wdata0 = 32'hDEADBEEF;
        sample();
        check("rst_gnt0",   64'(bus.gnt0),    64'(0));
        check("rst_wen",    64'(bus.mem_wen), 64'(0));
        check("rst_owner",  64'(owner),       64'(OWNER_IDLE));
        check("rst_rvalid", 64'(bus.rvalid0), 64'(0));

        // First request after release: write granted the same cycle.
        next_cycle();
        rst = 1'b1;
        sample();
        check("wr_gnt0",  64'(bus.gnt0),      64'(1));
        check("wr_gnt1",  64'(bus.gnt1),      64'(0));
        check("wr_wen",   64'(bus.mem_wen),   64'(1));
        check("wr_addr",  64'(bus.mem_addr),  64'(16'h0010));
        check("wr_wdata", 64'(bus.mem_wdata), 64'(32'hDEADBEEF));

        // Read back the same word.
        next_cycle();
        bus.we0 = 1'b0;
        sample();
        check("rd_gnt0",  64'(bus.gnt0),    64'(1));
        check("rd_ren",   64'(bus.mem_ren), 64'(1));
        check("rd_wen",   64'(bus.mem_wen), 64'(0));
        check("rd_owner", 64'(owner),       64'(OWNER_P0));

        next_cycle();
        bus.req0 = 1'b0;
        sample();
        check("rd_rvalid0", 64'(bus.rvalid0),  64'(1));
        check("rd_rdata0",  64'(bus.rdata0),   64'(32'hDEADBEEF));
        check("rd_rvalid1", 64'(bus.rvalid1),  64'(0));
        check("idle_ren",   64'(bus.mem_ren),  64'(0));
        check("idle_addr",  64'(bus.mem_addr), 64'(0));

        // Reset while a read response is pending.
        next_cycle();
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'h0004;
        sample();
        check("mr_gnt0", 64'(bus.gnt0), 64'(1));
        next_cycle();
        rst = 1'b0;
        sample();
        check("mr_rvalid0", 64'(bus.rvalid0), 64'(0));
        check("mr_gnt0_rst", 64'(bus.gnt0),   64'(0));
        check("mr_ren_rst", 64'(bus.mem_ren), 64'(0));
        check("mr_owner",   64'(owner),       64'(OWNER_IDLE));

        // Release with both requesting: rr_ptr=0 picks port 0.
        next_cycle();
        rst = 1'b1;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 16'h0008;
        sample();
        check("tb_no_stale", 64'(bus.rvalid0),  64'(0));
        check("tb_gnt0",     64'(bus.gnt0),     64'(1));
        check("tb_gnt1",     64'(bus.gnt1),     64'(0));
        check("tb_addr",     64'(bus.mem_addr), 64'(16'h0004));

        next_cycle();
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        sample();
        check("tb_rvalid0", 64'(bus.rvalid0), 64'(1));
        check("tb_rdata0",  64'(bus.rdata0),  64'(32'hA000_0001));

        // Reassert both from idle: pointer now favours port 1.
        next_cycle();
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        sample();
        check("tb2_gnt1", 64'(bus.gnt1),     64'(1));
        check("tb2_gnt0", 64'(bus.gnt0),     64'(0));
        check("tb2_addr", 64'(bus.mem_addr), 64'(16'h0008));

        // Response to port 1 alongside a new grant to port 0.
        next_cycle();
        bus.req1 = 1'b0;
        sample();
        check("il_rvalid1a", 64'(bus.rvalid1), 64'(1));
        check("il_rdata1a",  64'(bus.rdata1),  64'(32'hA000_0002));
        check("il_rvalid0a", 64'(bus.rvalid0), 64'(0));
        check("il_gnt0",     64'(bus.gnt0),    64'(1));

        // Interleaved reads: port 1 granted while port 0 gets its data.
        next_cycle();
        bus.req0 = 1'b0; bus.req1 = 1'b1;
        sample();
        check("il_rvalid0", 64'(bus.rvalid0), 64'(1));
        check("il_rdata0",  64'(bus.rdata0),  64'(32'hA000_0001));
        check("il_rvalid1", 64'(bus.rvalid1), 64'(0));
        check("il_gnt1",    64'(bus.gnt1),    64'(1));

        next_cycle();
        bus.req1 = 1'b0;
        sample();
        check("il_rvalid1b", 64'(bus.rvalid1), 64'(1));
        check("il_rdata1b",  64'(bus.rdata1),  64'(32'hA000_0002));
        check("il_rvalid0b", 64'(bus.rvalid0), 64'(0));

        next_cycle();
        sample();
        check("idle_owner", 64'(owner), 64'(OWNER_IDLE));

        // Hold and preempt: port 0 continuous, port 1 joins at cycle 2.
        bus.we0 = 1'b1; bus.addr0 = 16'h0020; bus.wdata0 = 32'h1111_1111;
        bus.we1 = 1'b1; bus.addr1 = 16'h0030; bus.wdata1 = 32'h2222_2222;
        for (int i = 1; i <= 9; i++) begin
            next_cycle();
            bus.req0 = 1'b1;
            bus.req1 = (i >= 2);
            sample();
            if (i <= 8) begin
                check("hold_gnt0", 64'(bus.gnt0), 64'(1));
            end else begin
                check("preempt_gnt1", 64'(bus.gnt1),     64'(1));
                check("preempt_gnt0", 64'(bus.gnt0),     64'(0));
                check("preempt_addr", 64'(bus.mem_addr), 64'(16'h0030));
            end
        end

        // Withdraw: port 1 raises and drops req while port 0 owns below the limit.
        next_cycle();
        bus.req1 = 1'b0;
        sample();
        check("wd_gnt0_a", 64'(bus.gnt0), 64'(1));
        next_cycle();
        bus.req1 = 1'b1;
        sample();
        check("wd_gnt0_b", 64'(bus.gnt0),     64'(1));
        check("wd_gnt1_b", 64'(bus.gnt1),     64'(0));
        check("wd_addr_b", 64'(bus.mem_addr), 64'(16'h0020));
        next_cycle();
        bus.req1 = 1'b0;
        sample();
        check("wd_gnt0_c",  64'(bus.gnt0),      64'(1));
        check("wd_gnt1_c",  64'(bus.gnt1),      64'(0));
        check("wd_wdata_c", 64'(bus.mem_wdata), 64'(32'h1111_1111));

        next_cycle();
        bus.req0 = 1'b0;
        sample();
        check("end_wen", 64'(bus.mem_wen), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
